// File: rtl/lzd_pkg.sv
// rtl/lzd_pkg.sv - shared types and constants for the leading-one/zero normaliser
package lzd_pkg;

  typedef enum logic {LZ_ONE = 1'b0, LZ_ZERO = 1'b1} lz_mode_t;

  localparam int GRP = 8;

  function automatic int zp_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/lzd_grp_enc.sv
// rtl/lzd_grp_enc.sv - priority encoder for one 8-bit group, position counted from the group MSB
module lzd_grp_enc
  import lzd_pkg::*;
(
  input  logic [GRP-1:0]         data,
  output logic                   hit,
  output logic [$clog2(GRP)-1:0] pos
);

  localparam int PW = $clog2(GRP);

  always_comb begin
    hit = 1'b0;
    pos = '0;
    for (int i = 0; i < GRP; i++) begin
      if (!hit && data[GRP-1-i]) begin
        hit = 1'b1;
        pos = i[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/lzd_norm_pipe.sv
// rtl/lzd_norm_pipe.sv - elastic pipelined leading-one/zero detector with left normaliser
module lzd_norm_pipe
  import lzd_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(WIDTH)-1:0] out_zp,
  output logic                     out_zv,
  output logic [WIDTH-1:0]         out_norm,
  output logic                     out_mode,
  output logic [CNT_W-1:0]         zero_cnt,
  input  logic                     clr_cnt
);

  localparam int ZW = zp_w(WIDTH);
  localparam int NG = WIDTH / GRP;
  localparam int PW = $clog2(GRP);

  typedef struct packed {
    logic [NG-1:0]         hit;
    logic [NG-1:0][PW-1:0] pos;
    logic [WIDTH-1:0]      data;
    lz_mode_t              mode;
  } grp_t;

  typedef struct packed {
    logic [ZW-1:0]    zp;
    logic             zv;
    logic [WIDTH-1:0] norm;
    lz_mode_t         mode;
  } res_t;

  logic [STAGES-1:0]     v;
  logic [STAGES-1:0]     adv;
  logic [WIDTH-1:0]      scan;
  logic [NG-1:0]         grp_hit;
  logic [NG-1:0][PW-1:0] grp_pos;
  grp_t                  grp_c;
  grp_t                  grp_src;
  res_t                  res_c;
  res_t                  res_out;
  logic                  take;

  assign take = in_valid && in_ready;
  assign scan = (lz_mode_t'(in_mode) == LZ_ZERO) ? ~in_data : in_data;

  // group 0 is the most significant byte of the word
  for (genvar g = 0; g < NG; g++) begin : g_enc
    lzd_grp_enc u_enc (
      .data (scan[WIDTH-1-g*GRP -: GRP]),
      .hit  (grp_hit[g]),
      .pos  (grp_pos[g])
    );
  end

  always_comb begin
    grp_c.hit  = grp_hit;
    grp_c.pos  = grp_pos;
    grp_c.data = in_data;
    grp_c.mode = lz_mode_t'(in_mode);
  end

  // descending scan so the most significant hitting group wins
  always_comb begin
    res_c      = '0;
    res_c.mode = grp_src.mode;
    res_c.zv   = ~|grp_src.hit;
    for (int g = NG - 1; g >= 0; g--) begin
      if (grp_src.hit[g]) res_c.zp = ZW'(g * GRP) + ZW'(grp_src.pos[g]);
    end
    res_c.norm = res_c.zv ? '0 : grp_src.data << res_c.zp;
  end

  always_comb begin
    adv = '0;
    adv[STAGES-1] = !v[STAGES-1] || out_ready;
    for (int i = STAGES - 2; i >= 0; i--) adv[i] = !v[i] || adv[i+1];
  end

  assign in_ready  = adv[0];
  assign out_valid = v[STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
    end else begin
      if (adv[0]) v[0] <= in_valid;
      for (int i = 1; i < STAGES; i++) begin
        if (adv[i]) v[i] <= v[i-1];
      end
    end
  end

  if (STAGES == 1) begin : g_one
    res_t res_q;

    assign grp_src = grp_c;
    assign res_out = res_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    res_q <= '0;
      else if (take) res_q <= res_c;
    end
  end else begin : g_multi
    grp_t grp_q;
    res_t res_q [1:STAGES-1];

    assign grp_src = grp_q;
    assign res_out = res_q[STAGES-1];

    // slot 1 holds group flags, slot 2 the final encode, later slots only retime
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        grp_q <= '0;
        for (int i = 1; i < STAGES; i++) res_q[i] <= '0;
      end else begin
        if (take) grp_q <= grp_c;
        if (v[0] && adv[1]) res_q[1] <= res_c;
        for (int i = 2; i < STAGES; i++) begin
          if (v[i-1] && adv[i]) res_q[i] <= res_q[i-1];
        end
      end
    end
  end

  assign out_zp   = res_out.zp;
  assign out_zv   = res_out.zv;
  assign out_norm = res_out.norm;
  assign out_mode = res_out.mode;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   zero_cnt <= '0;
    else if (clr_cnt)                             zero_cnt <= '0;
    else if (out_valid && out_ready && res_out.zv
             && zero_cnt != {CNT_W{1'b1}})        zero_cnt <= zero_cnt + 1'b1;
  end

endmodule
